// File: rtl/dcp_dark_min_filter.sv
// 3x3 spatial minimum (erosion) over a raster-order 8-bit dark-channel stream, with an
// end-of-frame flush. Optional atmospheric max output when DCP_MINF_ATMOS_EN is defined.
module dcp_dark_min_filter #(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic       pixelclk,
   input  logic       reset_n,
   input  logic [7:0] i_dark,
   input  logic       i_data_valid,
   output logic       o_ready,
   output logic [7:0] o_dark,
   output logic       o_data_valid,
   output logic       o_frame_done
`ifdef DCP_MINF_ATMOS_EN
   ,
   output logic [7:0] o_frame_max,
   output logic       o_max_valid
`endif
);

   localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int unsigned FW = $clog2(IMG_W + 1);
   localparam logic [CW-1:0] ColLast   = CW'(IMG_W - 1);
   localparam logic [RW-1:0] RowLast   = RW'(IMG_H - 1);
   localparam logic [FW-1:0] FlushLast = FW'(IMG_W);

   typedef enum logic [1:0] {StFill, StRun, StFlush} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   in_col_q, cen_col_q, s1_col_q;
   logic [RW-1:0]   in_row_q, cen_row_q, s1_row_q;
   logic [FW-1:0]   flush_cnt_q;
   logic [7:0]      lb0 [IMG_W];
   logic [7:0]      lb1 [IMG_W];
   logic [7:0]      win_q [3][3];
   logic [7:0]      tap [3][3];
   logic [7:0]      row_min [3];
   logic [7:0]      s2_min_q [3];
   logic            s1_valid_q, s1_last_q, s2_valid_q, s2_last_q;

   logic       accept, flush_beat, beat, eval, fill_done, frame_end_in, flush_end;
   logic [7:0] pix;

   function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
      return (a < b) ? a : b;
   endfunction

   always_comb begin
      accept       = i_data_valid && (state_q != StFlush);
      flush_beat   = (state_q == StFlush);
      beat         = accept || flush_beat;
      eval         = (accept && (state_q == StRun)) || flush_beat;
      pix          = flush_beat ? 8'hFF : i_dark;
      // Beat index IMG_W (row 1, col 0) completes the fill; the next beat evaluates centre 0.
      fill_done    = accept && (state_q == StFill) && (in_row_q == RW'(1)) && (in_col_q == '0);
      frame_end_in = accept && (state_q == StRun) && (in_row_q == RowLast) && (in_col_q == ColLast);
      flush_end    = flush_beat && (flush_cnt_q == FlushLast);
   end

   // FSM: state register
   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) state_q <= StFill;
      else          state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFill:  if (fill_done)    state_d = StRun;
         StRun:   if (frame_end_in) state_d = StFlush;
         StFlush: if (flush_end)    state_d = StFill;
         default:                   state_d = StFill;
      endcase
   end

   // FSM: outputs
   always_comb begin
      o_ready = (state_q != StFlush);
   end

   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         in_col_q    <= '0;
         in_row_q    <= '0;
         cen_col_q   <= '0;
         cen_row_q   <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (beat) begin
            // Flush beats run past the frame; re-align for the next frame's first pixel.
            if (flush_end) begin
               in_col_q <= '0;
               in_row_q <= '0;
            end else if (in_col_q == ColLast) begin
               in_col_q <= '0;
               in_row_q <= (in_row_q == RowLast) ? '0 : in_row_q + RW'(1);
            end else begin
               in_col_q <= in_col_q + CW'(1);
            end
         end
         if (eval) begin
            if (cen_col_q == ColLast) begin
               cen_col_q <= '0;
               cen_row_q <= (cen_row_q == RowLast) ? '0 : cen_row_q + RW'(1);
            end else begin
               cen_col_q <= cen_col_q + CW'(1);
            end
         end
         if (flush_beat) flush_cnt_q <= flush_end ? '0 : flush_cnt_q + FW'(1);
      end
   end

   // Line buffers hold the two previous rows; contents before the first rows are masked.
   always_ff @(posedge pixelclk) begin
      if (beat) begin
         lb1[in_col_q] <= lb0[in_col_q];
         lb0[in_col_q] <= pix;
      end
   end

   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) win_q[i][j] <= 8'hFF;
         end
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_col_q   <= '0;
         s1_row_q   <= '0;
      end else begin
         if (beat) begin
            for (int i = 0; i < 3; i++) begin
               win_q[i][0] <= win_q[i][1];
               win_q[i][1] <= win_q[i][2];
            end
            win_q[0][2] <= lb1[in_col_q];
            win_q[1][2] <= lb0[in_col_q];
            win_q[2][2] <= pix;
         end
         s1_valid_q <= eval;
         if (eval) begin
            s1_col_q  <= cen_col_q;
            s1_row_q  <= cen_row_q;
            s1_last_q <= (cen_row_q == RowLast) && (cen_col_q == ColLast);
         end
      end
   end

   // Taps outside the image read as FF; column masking uses the centre column only.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            tap[i][j] = win_q[i][j];
            if ((i == 0 && s1_row_q == '0) || (i == 2 && s1_row_q == RowLast) ||
                (j == 0 && s1_col_q == '0) || (j == 2 && s1_col_q == ColLast)) begin
               tap[i][j] = 8'hFF;
            end
         end
         row_min[i] = min2(min2(tap[i][0], tap[i][1]), tap[i][2]);
      end
   end

   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 3; i++) s2_min_q[i] <= 8'hFF;
         s2_valid_q   <= 1'b0;
         s2_last_q    <= 1'b0;
         o_dark       <= 8'h00;
         o_data_valid <= 1'b0;
         o_frame_done <= 1'b0;
      end else begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            for (int i = 0; i < 3; i++) s2_min_q[i] <= row_min[i];
            s2_last_q <= s1_last_q;
         end
         o_data_valid <= s2_valid_q;
         o_frame_done <= s2_valid_q && s2_last_q;
         if (s2_valid_q) o_dark <= min2(min2(s2_min_q[0], s2_min_q[1]), s2_min_q[2]);
      end
   end

`ifdef DCP_MINF_ATMOS_EN
   logic [7:0] run_max_q;
   logic [7:0] max_now;

   always_comb begin
      max_now = (o_dark > run_max_q) ? o_dark : run_max_q;
   end

   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         run_max_q   <= 8'h00;
         o_frame_max <= 8'h00;
         o_max_valid <= 1'b0;
      end else begin
         o_max_valid <= 1'b0;
         if (o_data_valid) begin
            if (o_frame_done) begin
               o_frame_max <= max_now;
               o_max_valid <= 1'b1;
               run_max_q   <= 8'h00;
            end else begin
               run_max_q   <= max_now;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_dcp_dark_min_filter.sv
// Scoreboard bench for dcp_dark_min_filter: a plain-loop 3x3 minimum model fills an expectation
// queue per frame; a negedge monitor pops and compares every output strobe.
module tb_dcp_dark_min_filter;

   localparam int W    = 8;
   localparam int H    = 4;
   localparam int NPIX = W * H;

   logic       pixelclk = 1'b0;
   logic       reset_n;
   logic [7:0] i_dark;
   logic       i_data_valid;
   logic       o_ready;
   logic [7:0] o_dark;
   logic       o_data_valid;
   logic       o_frame_done;
`ifdef DCP_MINF_ATMOS_EN
   logic [7:0] o_frame_max;
   logic       o_max_valid;
`endif

   dcp_dark_min_filter #(.IMG_W(W), .IMG_H(H)) dut (
      .pixelclk     (pixelclk),
      .reset_n      (reset_n),
      .i_dark       (i_dark),
      .i_data_valid (i_data_valid),
      .o_ready      (o_ready),
      .o_dark       (o_dark),
      .o_data_valid (o_data_valid),
      .o_frame_done (o_frame_done)
`ifdef DCP_MINF_ATMOS_EN
      ,
      .o_frame_max  (o_frame_max),
      .o_max_valid  (o_max_valid)
`endif
   );

   always #5 pixelclk = ~pixelclk;

   typedef struct packed {
      logic [7:0] dark;
      logic       done;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] max_q[$];
   logic [7:0] img [NPIX];
   int n_checks = 0;
   int n_pass   = 0;
   int n_done   = 0;
   int partial_done = 0;
   int low_cnt  = 0;
   bit ignore   = 1'b0;
   bit max_pending = 1'b0;

   task automatic chk(input string name, input bit ok, input int act, input int req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
   endtask

   // Reference: each centre is the min over in-image neighbours; outside taps contribute nothing.
   task automatic model_push();
      int mx = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            int m = 255;
            exp_t e;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  int rr = r + dr;
                  int cc = c + dc;
                  if (rr >= 0 && rr < H && cc >= 0 && cc < W && int'(img[rr*W+cc]) < m)
                     m = int'(img[rr*W+cc]);
               end
            end
            e.dark = 8'(m);
            e.done = (r == H-1) && (c == W-1);
            exp_q.push_back(e);
            if (m > mx) mx = m;
         end
      end
      max_q.push_back(8'(mx));
   endtask

   task automatic drive_beat(input logic [7:0] pix);
      int guard = 0;
      i_data_valid = 1'b0;
      while (!o_ready && guard < 100) begin
         @(posedge pixelclk); #1;
         guard++;
      end
      if (guard >= 100) chk("ready_timeout", 1'b0, 0, 1);
      i_dark       = pix;
      i_data_valid = 1'b1;
      @(posedge pixelclk); #1;
      i_data_valid = 1'b0;
   endtask

   // gap_mode: 0 none, 1 idle cycle between every beat, 2 random idle cycles
   task automatic send_frame(input int gap_mode, input int nbeats);
      for (int n = 0; n < nbeats; n++) begin
         if (gap_mode == 1 && n > 0) begin
            i_data_valid = 1'b0;
            @(posedge pixelclk); #1;
         end else if (gap_mode == 2) begin
            while ($urandom_range(2) == 0) begin
               i_data_valid = 1'b0;
               i_dark = 8'($urandom);
               @(posedge pixelclk); #1;
            end
         end
         drive_beat(img[n]);
      end
   endtask

   task automatic check_reset_state();
      chk("rst_dark",  o_dark == 8'd0,     int'(o_dark),       0);
      chk("rst_valid", o_data_valid == 0,  int'(o_data_valid), 0);
      chk("rst_done",  o_frame_done == 0,  int'(o_frame_done), 0);
      chk("rst_ready", o_ready == 1,       int'(o_ready),      1);
   endtask

   always @(negedge pixelclk) begin
      if (!reset_n) begin
         low_cnt     = 0;
         max_pending = 1'b0;
      end else begin
`ifdef DCP_MINF_ATMOS_EN
         if (max_pending) begin
            logic [7:0] em;
            em = (max_q.size() > 0) ? max_q.pop_front() : 8'h00;
            chk("max_valid", o_max_valid == 1'b1, int'(o_max_valid), 1);
            chk("frame_max", o_frame_max == em,   int'(o_frame_max), int'(em));
            max_pending = 1'b0;
         end
`endif
         if (o_frame_done) begin
            if (ignore) partial_done++;
            else n_done++;
         end
         if (o_data_valid && !ignore) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 1'b0, int'(o_dark), -1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("dark", o_dark == e.dark,       int'(o_dark),       int'(e.dark));
               chk("done", o_frame_done == e.done, int'(o_frame_done), int'(e.done));
               if (o_frame_done) max_pending = 1'b1;
            end
         end else if (o_frame_done && !ignore) begin
            chk("done_without_valid", 1'b0, 1, 0);
         end
         if (!o_ready) begin
            low_cnt++;
         end else if (low_cnt > 0) begin
            chk("ready_low_len", low_cnt == W + 1, low_cnt, W + 1);
            low_cnt = 0;
         end
      end
   end

   task automatic drain();
      int guard = 0;
      while ((exp_q.size() > 0 || max_pending || !o_ready) && guard < 300) begin
         @(posedge pixelclk); #1;
         guard++;
      end
      repeat (4) @(posedge pixelclk);
      #1;
      chk("drain_queue_empty", exp_q.size() == 0, exp_q.size(), 0);
   endtask

   initial begin
      int frames = 0;
      reset_n      = 1'b0;
      i_dark       = 8'd0;
      i_data_valid = 1'b0;
      repeat (3) @(negedge pixelclk);
      check_reset_state();
      reset_n = 1'b1;
      @(posedge pixelclk); #1;

      // constant 100
      for (int n = 0; n < NPIX; n++) img[n] = 8'd100;
      model_push(); send_frame(0, NPIX); frames++;
      // single dark pixel at (1,1)
      img[1*W+1] = 8'd0;
      model_push(); send_frame(0, NPIX); frames++;
      // single dark pixel at (0,7): no wrap into (1,0)
      for (int n = 0; n < NPIX; n++) img[n] = 8'd100;
      img[W-1] = 8'd0;
      model_push(); send_frame(0, NPIX); frames++;
      // ramp with valid toggling every clock
      for (int n = 0; n < NPIX; n++) img[n] = 8'(n);
      model_push(); send_frame(1, NPIX); frames++;
      // random content, random gaps
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < NPIX; n++) img[n] = 8'($urandom);
         model_push(); send_frame(2, NPIX); frames++;
      end
      drain();

      // partial frame killed by reset
      ignore = 1'b1;
      for (int n = 0; n < NPIX; n++) img[n] = 8'($urandom_range(255, 0));
      send_frame(0, 13);
      reset_n = 1'b0;
      @(negedge pixelclk);
      check_reset_state();
      @(negedge pixelclk);
      reset_n = 1'b1;
      @(posedge pixelclk); #1;
      ignore = 1'b0;
      chk("no_done_in_partial", partial_done == 0, partial_done, 0);

      for (int n = 0; n < NPIX; n++) img[n] = 8'd50;
      model_push(); send_frame(0, NPIX); frames++;
      for (int n = 0; n < NPIX; n++) img[n] = 8'd5;
      model_push(); send_frame(0, NPIX); frames++;
      drain();

      chk("frame_done_count", n_done == frames, n_done, frames);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0, required 1");
      $fatal(1, "timeout");
   end

endmodule
